// File: rtl/color_filter_pkg.sv
// Shared constants and types for the colour filter: mode encoding,
// fixed-point coefficient rows and the per-channel coefficient selector.
package color_filter_pkg;

    localparam int COEF_FRAC = 8;

    typedef enum logic [1:0] {
        MODE_BYPASS = 2'd0,
        MODE_SEPIA  = 2'd1,
        MODE_GRAY   = 2'd2,
        MODE_INVERT = 2'd3
    } mode_e;

    typedef struct packed {
        logic [7:0] c0;
        logic [7:0] c1;
        logic [7:0] c2;
    } coef_row_t;

    localparam coef_row_t SEPIA_R   = '{c0: 8'd101, c1: 8'd197, c2: 8'd48};
    localparam coef_row_t SEPIA_G   = '{c0: 8'd89,  c1: 8'd176, c2: 8'd43};
    localparam coef_row_t SEPIA_B   = '{c0: 8'd70,  c1: 8'd137, c2: 8'd34};
    localparam coef_row_t GRAY_Y    = '{c0: 8'd77,  c1: 8'd150, c2: 8'd29};
    localparam coef_row_t COEF_ZERO = '{c0: 8'd0,   c1: 8'd0,   c2: 8'd0};

    // Bypass and invert never use the MAC result, so their rows are zero.
    function automatic coef_row_t coef_sel(input mode_e mode, input logic [1:0] ch);
        coef_row_t row;
        row = COEF_ZERO;
        case (mode)
            MODE_SEPIA: begin
                case (ch)
                    2'd0:    row = SEPIA_R;
                    2'd1:    row = SEPIA_G;
                    default: row = SEPIA_B;
                endcase
            end
            MODE_GRAY: row = GRAY_Y;
            default:   row = COEF_ZERO;
        endcase
        return row;
    endfunction

endpackage

// File: rtl/color_filter_mac3.sv
// One output channel: three registered products, sum, >>COEF_FRAC, saturate,
// with a registered alternate value that overrides the MAC result.
module color_mac3
    import color_filter_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    input  coef_row_t        coef,
    input  logic             alt_sel,
    input  logic [WIDTH-1:0] alt_val,
    output logic [WIDTH-1:0] y
);

    localparam int PW = WIDTH + 8;
    localparam int SW = WIDTH + 10;
    localparam logic [WIDTH-1:0] PIX_MAX = {WIDTH{1'b1}};

    logic [PW-1:0]    p0_r, p1_r, p2_r;
    logic             alt_sel_r;
    logic [WIDTH-1:0] alt_val_r;
    logic [SW-1:0]    sum_s;
    logic [SW-1:0]    shifted_s;
    logic [WIDTH-1:0] sat_s;

    // Product stage: the three channel-by-coefficient multiplies.
    always_ff @(posedge clk) begin
        if (!rst) begin
            p0_r      <= {PW{1'b0}};
            p1_r      <= {PW{1'b0}};
            p2_r      <= {PW{1'b0}};
            alt_sel_r <= 1'b0;
            alt_val_r <= {WIDTH{1'b0}};
        end else begin
            p0_r      <= {{8{1'b0}}, a} * {{WIDTH{1'b0}}, coef.c0};
            p1_r      <= {{8{1'b0}}, b} * {{WIDTH{1'b0}}, coef.c1};
            p2_r      <= {{8{1'b0}}, c} * {{WIDTH{1'b0}}, coef.c2};
            alt_sel_r <= alt_sel;
            alt_val_r <= alt_val;
        end
    end

    // Sum, drop the fractional bits, clamp anything above full scale.
    always_comb begin
        sum_s     = {2'b00, p0_r} + {2'b00, p1_r} + {2'b00, p2_r};
        shifted_s = sum_s >> COEF_FRAC;
        if (|shifted_s[SW-1:WIDTH]) begin
            sat_s = PIX_MAX;
        end else begin
            sat_s = shifted_s[WIDTH-1:0];
        end
    end

    // Output stage: registered result or alternate value.
    always_ff @(posedge clk) begin
        if (!rst) begin
            y <= {WIDTH{1'b0}};
        end else if (alt_sel_r) begin
            y <= alt_val_r;
        end else begin
            y <= sat_s;
        end
    end

endmodule

// File: rtl/color_filter.sv
// Three-stage per-pixel colour filter (bypass/sepia/grayscale/invert) with a
// sideband delayed in lockstep with the pixel data.
module color_filter
    import color_filter_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int USER_W = 21
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        mode,
    input  logic              valid_in,
    input  logic [WIDTH-1:0]  r_in,
    input  logic [WIDTH-1:0]  g_in,
    input  logic [WIDTH-1:0]  b_in,
    input  logic [USER_W-1:0] user_in,
    output logic              valid_out,
    output logic [WIDTH-1:0]  r_out,
    output logic [WIDTH-1:0]  g_out,
    output logic [WIDTH-1:0]  b_out,
    output logic [USER_W-1:0] user_out
);

    localparam logic [WIDTH-1:0] PIX_MAX = {WIDTH{1'b1}};

    logic [WIDTH-1:0]  r_r, g_r, b_r;
    mode_e             mode_r;
    logic              valid_r, valid_d_r;
    logic [USER_W-1:0] user_r, user_d_r;
    logic              alt_sel_s;
    logic [WIDTH-1:0]  alt_r_s, alt_g_s, alt_b_s;
    coef_row_t         coef_r_s, coef_g_s, coef_b_s;

    // Input stage: the mode is captured here and travels with the pixel.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_r     <= {WIDTH{1'b0}};
            g_r     <= {WIDTH{1'b0}};
            b_r     <= {WIDTH{1'b0}};
            mode_r  <= MODE_BYPASS;
            valid_r <= 1'b0;
            user_r  <= {USER_W{1'b0}};
        end else begin
            r_r     <= r_in;
            g_r     <= g_in;
            b_r     <= b_in;
            mode_r  <= mode_e'(mode);
            valid_r <= valid_in;
            user_r  <= user_in;
        end
    end

    // Valid and sideband follow the two MAC stages.
    always_ff @(posedge clk) begin
        if (!rst) begin
            valid_d_r <= 1'b0;
            user_d_r  <= {USER_W{1'b0}};
            valid_out <= 1'b0;
            user_out  <= {USER_W{1'b0}};
        end else begin
            valid_d_r <= valid_r;
            user_d_r  <= user_r;
            valid_out <= valid_d_r;
            user_out  <= user_d_r;
        end
    end

    // Bypass and invert skip the multipliers via the alternate path.
    always_comb begin
        alt_sel_s = 1'b0;
        alt_r_s   = r_r;
        alt_g_s   = g_r;
        alt_b_s   = b_r;
        if (mode_r == MODE_INVERT) begin
            alt_sel_s = 1'b1;
            alt_r_s   = PIX_MAX - r_r;
            alt_g_s   = PIX_MAX - g_r;
            alt_b_s   = PIX_MAX - b_r;
        end else if (mode_r == MODE_BYPASS) begin
            alt_sel_s = 1'b1;
        end else begin
            alt_sel_s = 1'b0;
        end
    end

    // Coefficient rows for each output channel from the registered mode.
    always_comb begin
        coef_r_s = coef_sel(mode_r, 2'd0);
        coef_g_s = coef_sel(mode_r, 2'd1);
        coef_b_s = coef_sel(mode_r, 2'd2);
    end

    color_mac3 #(.WIDTH(WIDTH)) u_mac_r (
        .clk(clk), .rst(rst), .a(r_r), .b(g_r), .c(b_r), .coef(coef_r_s),
        .alt_sel(alt_sel_s), .alt_val(alt_r_s), .y(r_out)
    );

    color_mac3 #(.WIDTH(WIDTH)) u_mac_g (
        .clk(clk), .rst(rst), .a(r_r), .b(g_r), .c(b_r), .coef(coef_g_s),
        .alt_sel(alt_sel_s), .alt_val(alt_g_s), .y(g_out)
    );

    color_mac3 #(.WIDTH(WIDTH)) u_mac_b (
        .clk(clk), .rst(rst), .a(r_r), .b(g_r), .c(b_r), .coef(coef_b_s),
        .alt_sel(alt_sel_s), .alt_val(alt_b_s), .y(b_out)
    );

endmodule
